// File: rtl/sensor_sample_buffer_if.sv
// sensor_sample_buffer_if
//
// Purpose: bundles the register-side control/readback signals and the
// sensor-side sample handshake of the sample-buffer controller.
//
// Signals:
//   sctrl_en        collection enable (level), wrapper -> buffer
//   sctrl_clear     buffer clear (level), wrapper -> buffer
//   sctrl_addr      read word index, wrapper -> buffer
//   sctrl_out       buffer entry at sctrl_addr, buffer -> wrapper
//   sctrl_interrupt buffer full, buffer -> wrapper
//   sensor_ready    sample valid, one sample per high cycle, sensor -> buffer
//   sensor_out      sensor sample, sensor -> buffer
//   sensor_en       sensor request/enable, buffer -> sensor
//   sctrl_drop_cnt  (only with SENSOR_BUF_DROP_CNT_EN) saturating count of
//                   samples offered while the buffer was full
//
// Modports: slave = the buffer controller, master = the wrapper/sensor side.
// Optional feature macro: SENSOR_BUF_DROP_CNT_EN.

interface sensor_sample_buffer_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);

  logic              sctrl_en;
  logic              sctrl_clear;
  logic [ADDR_W-1:0] sctrl_addr;
  logic [DATA_W-1:0] sctrl_out;
  logic              sctrl_interrupt;
  logic              sensor_ready;
  logic [DATA_W-1:0] sensor_out;
  logic              sensor_en;
`ifdef SENSOR_BUF_DROP_CNT_EN
  logic [7:0]        sctrl_drop_cnt;
`endif

`ifdef SENSOR_BUF_DROP_CNT_EN
  modport slave (
    input  sctrl_en, sctrl_clear, sctrl_addr, sensor_ready, sensor_out,
    output sctrl_out, sctrl_interrupt, sensor_en, sctrl_drop_cnt
  );

  modport master (
    output sctrl_en, sctrl_clear, sctrl_addr, sensor_ready, sensor_out,
    input  sctrl_out, sctrl_interrupt, sensor_en, sctrl_drop_cnt
  );
`else
  modport slave (
    input  sctrl_en, sctrl_clear, sctrl_addr, sensor_ready, sensor_out,
    output sctrl_out, sctrl_interrupt, sensor_en
  );

  modport master (
    output sctrl_en, sctrl_clear, sctrl_addr, sensor_ready, sensor_out,
    input  sctrl_out, sctrl_interrupt, sensor_en
  );
`endif

endinterface

// File: rtl/sensor_sample_buffer.sv
// sensor_sample_buffer
//
// Purpose: sample-buffer controller between the external sensor and the
// sensor AXI wrapper. While enabled it captures one sensor word per
// sensor_ready cycle into a DEPTH-entry flop memory, then stops collecting
// and raises sctrl_interrupt once the buffer is full. Any entry can be read
// combinationally by word address; sctrl_clear rewinds the write pointer
// without zeroing the stored data.
//
// Ports:
//   clk  clock
//   rst  asynchronous, active-low reset
//   bus  sensor_sample_buffer_if.slave (control, readback and sensor handshake)
//
// Parameters: DEPTH (power of two), ADDR_W = log2(DEPTH), DATA_W sample width.
// Optional feature macro: SENSOR_BUF_DROP_CNT_EN adds bus.sctrl_drop_cnt, an
// 8-bit saturating count of samples offered while FULL.

module sensor_sample_buffer #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  sensor_sample_buffer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FULL    = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wptr_q,  wptr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic              wr_en;
  logic              last_write;

`ifdef SENSOR_BUF_DROP_CNT_EN
  logic [7:0]        drop_cnt_q, drop_cnt_d;
`endif

  // Clear wins over a write in the same cycle, so the sample is dropped.
  assign wr_en      = (state_q == COLLECT) && bus.sensor_ready && !bus.sctrl_clear;
  assign last_write = wr_en && (wptr_q == ADDR_W'(DEPTH - 1));

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      mem_q   <= '{default: '0};
`ifdef SENSOR_BUF_DROP_CNT_EN
      drop_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      mem_q   <= mem_d;
`ifdef SENSOR_BUF_DROP_CNT_EN
      drop_cnt_q <= drop_cnt_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    mem_d   = mem_q;

    if (wr_en) begin
      mem_d[wptr_q] = bus.sensor_out;
      // Natural wrap of the pointer brings it back to 0 on the final write.
      wptr_d        = wptr_q + ADDR_W'(1);
    end

    if (bus.sctrl_clear) begin
      state_d = IDLE;
      wptr_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.sctrl_en) state_d = COLLECT;
        end
        COLLECT: begin
          // Filling the last slot takes precedence over a disable, since
          // FULL is only left through clear.
          if (last_write)           state_d = FULL;
          else if (!bus.sctrl_en)   state_d = IDLE;
        end
        FULL: begin
          state_d = FULL;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

`ifdef SENSOR_BUF_DROP_CNT_EN
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (bus.sctrl_clear) begin
      drop_cnt_d = '0;
    end else if ((state_q == FULL) && bus.sensor_ready && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end
`endif

  // Output decode: strobes come straight from the registered state.
  always_comb begin
    bus.sensor_en       = (state_q == COLLECT);
    bus.sctrl_interrupt = (state_q == FULL);
    bus.sctrl_out       = mem_q[bus.sctrl_addr];
`ifdef SENSOR_BUF_DROP_CNT_EN
    bus.sctrl_drop_cnt  = drop_cnt_q;
`endif
  end

endmodule

// File: tb/tb_sensor_sample_buffer.sv
// tb_sensor_sample_buffer
//
// Purpose: randomized, self-checking bench for sensor_sample_buffer. A
// behavioural model tracks how many samples have been accepted since the
// last clear, whether collection is active, and the buffer contents; the
// DUT's strobes and readback are compared against it every cycle.
// Optional feature macro: SENSOR_BUF_DROP_CNT_EN (drop counter checks).

module tb_sensor_sample_buffer;

  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;

  logic clk;
  logic rst;

  sensor_sample_buffer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sensor_sample_buffer #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;

  // Reference model
  logic [DATA_W-1:0] m_mem [DEPTH];
  int                m_count;
  bit                m_active;
  int                m_drops;

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_count  = 0;
    m_active = 0;
    m_drops  = 0;
  endfunction

  function automatic bit m_full();
    return (m_count == DEPTH);
  endfunction

  function automatic bit exp_sensor_en();
    return m_active && !m_full();
  endfunction

  function automatic void model_step(input bit en, input bit clr, input bit rdy,
                                     input logic [DATA_W-1:0] data);
    if (clr) begin
      m_count  = 0;
      m_active = 0;
      m_drops  = 0;
    end else if (m_full()) begin
      if (rdy && m_drops < 255) m_drops++;
    end else if (m_active) begin
      if (rdy) begin
        m_mem[m_count] = data;
        m_count++;
      end
      if (m_full())  m_active = 0;
      else if (!en)  m_active = 0;
    end else if (en) begin
      m_active = 1;
    end
  endfunction

  // Drives one clock cycle of inputs, advances the model, samples at edge+1.
  task automatic tick(input bit en, input bit clr, input bit rdy,
                      input logic [DATA_W-1:0] data);
    bus.sctrl_en     = en;
    bus.sctrl_clear  = clr;
    bus.sensor_ready = rdy;
    bus.sensor_out   = data;
    @(posedge clk);
    model_step(en, clr, rdy, data);
    #1;
  endtask

  task automatic test_reset();
    logic [ADDR_W-1:0] a;
    rst = 1'b0;
    bus.sctrl_en = 0; bus.sctrl_clear = 0; bus.sensor_ready = 0;
    bus.sensor_out = '0; bus.sctrl_addr = '0;
    model_reset();
    #12;
    vectors++;
    if (bus.sensor_en !== 1'b0) begin
      miscompares++; $display("[TB] FAIL reset_sensor_en: got %b expected 0", bus.sensor_en);
    end
    vectors++;
    if (bus.sctrl_interrupt !== 1'b0) begin
      miscompares++; $display("[TB] FAIL reset_interrupt: got %b expected 0", bus.sctrl_interrupt);
    end
    for (int i = 0; i < 3; i++) begin
      a = ADDR_W'($urandom_range(0, DEPTH - 1));
      bus.sctrl_addr = a;
      #1;
      vectors++;
      if (bus.sctrl_out !== 32'h0) begin
        miscompares++; $display("[TB] FAIL reset_out[%0d]: got %h expected 0", a, bus.sctrl_out);
      end
    end
`ifdef SENSOR_BUF_DROP_CNT_EN
    vectors++;
    if (bus.sctrl_drop_cnt !== 8'd0) begin
      miscompares++; $display("[TB] FAIL reset_drop_cnt: got %0d expected 0", bus.sctrl_drop_cnt);
    end
`endif
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_basic_fill();
    tick(1, 0, 0, '0);
    vectors++;
    if (bus.sensor_en !== 1'b1) begin
      miscompares++; $display("[TB] FAIL fill_start_sensor_en: got %b expected 1", bus.sensor_en);
    end
    for (int i = 0; i < DEPTH; i++) begin
      tick(1, 0, 1, 32'h100 + 32'(i));
      vectors++;
      if (bus.sctrl_interrupt !== m_full() || bus.sensor_en !== exp_sensor_en()) begin
        miscompares++;
        $display("[TB] FAIL fill_strobes[%0d]: got int=%b en=%b expected int=%b en=%b",
                 i, bus.sctrl_interrupt, bus.sensor_en, m_full(), exp_sensor_en());
      end
    end
    vectors++;
    if (bus.sctrl_interrupt !== 1'b1 || bus.sensor_en !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL fill_full: got int=%b en=%b expected int=1 en=0",
               bus.sctrl_interrupt, bus.sensor_en);
    end
    for (int i = 0; i < DEPTH; i++) begin
      tick(1, 0, 0, '0);
      bus.sctrl_addr = ADDR_W'(i);
      #1;
      vectors++;
      if (bus.sctrl_out !== 32'h100 + 32'(i)) begin
        miscompares++;
        $display("[TB] FAIL fill_readback[%0d]: got %h expected %h", i, bus.sctrl_out, 32'h100 + 32'(i));
      end
    end
  endtask

  task automatic test_gapped_paused();
    logic [DATA_W-1:0] prev;
    int cyc;
    bit en;
    tick(1, 1, 0, '0);
    tick(1, 0, 0, '0);
    cyc = 0;
    while (!m_full() && cyc < 400) begin
      en = !(cyc >= 20 && cyc < 25);
      tick(en, 0, cyc[0], 32'h2000_0000 + 32'(cyc));
      vectors++;
      if (bus.sensor_en !== exp_sensor_en() || bus.sctrl_interrupt !== m_full()) begin
        miscompares++;
        $display("[TB] FAIL gap_strobes[cyc %0d]: got en=%b int=%b expected en=%b int=%b",
                 cyc, bus.sensor_en, bus.sctrl_interrupt, exp_sensor_en(), m_full());
      end
      cyc++;
    end
    vectors++;
    if (!m_full() || bus.sctrl_interrupt !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL gap_fill_timeout: got int=%b after %0d cycles expected 1", bus.sctrl_interrupt, cyc);
    end
    prev = '0;
    for (int i = 0; i < DEPTH; i++) begin
      tick(1, 0, 0, '0);
      bus.sctrl_addr = ADDR_W'(i);
      #1;
      vectors++;
      if (bus.sctrl_out !== m_mem[i] || (i > 0 && bus.sctrl_out <= prev)) begin
        miscompares++;
        $display("[TB] FAIL gap_readback[%0d]: got %h expected %h (prev %h)", i, bus.sctrl_out, m_mem[i], prev);
      end
      prev = bus.sctrl_out;
    end
  endtask

  task automatic test_clear_priority();
    logic [DATA_W-1:0] old5;
    tick(1, 1, 0, '0);
    tick(1, 0, 0, '0);
    for (int i = 0; i < 5; i++) tick(1, 0, 1, $urandom);
    old5 = m_mem[5];
    tick(1, 1, 1, 32'hDEAD);
    vectors++;
    if (bus.sensor_en !== 1'b0 || bus.sctrl_interrupt !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL clrpri_strobes: got en=%b int=%b expected en=0 int=0", bus.sensor_en, bus.sctrl_interrupt);
    end
    bus.sctrl_addr = ADDR_W'(5);
    #1;
    vectors++;
    if (bus.sctrl_out !== old5) begin
      miscompares++; $display("[TB] FAIL clrpri_mem5: got %h expected %h", bus.sctrl_out, old5);
    end
    tick(1, 0, 0, '0);
    tick(1, 0, 1, 32'hBEEF);
    bus.sctrl_addr = '0;
    #1;
    vectors++;
    if (bus.sctrl_out !== 32'hBEEF) begin
      miscompares++; $display("[TB] FAIL clrpri_addr0: got %h expected 0000beef", bus.sctrl_out);
    end
    bus.sctrl_addr = ADDR_W'(1);
    #1;
    vectors++;
    if (bus.sctrl_out !== m_mem[1]) begin
      miscompares++; $display("[TB] FAIL clrpri_addr1: got %h expected %h", bus.sctrl_out, m_mem[1]);
    end
  endtask

  task automatic test_full_then_clear();
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] old1;
    tick(1, 1, 0, '0);
    tick(1, 0, 0, '0);
    for (int i = 0; i < DEPTH; i++) tick(1, 0, 1, $urandom);
    for (int i = 0; i < 20; i++) begin
      bus.sctrl_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
      tick(i % 3 != 0, 0, 1'(i % 2), $urandom);
      a = bus.sctrl_addr;
      vectors++;
      if (bus.sctrl_interrupt !== 1'b1 || bus.sensor_en !== 1'b0 || bus.sctrl_out !== m_mem[a]) begin
        miscompares++;
        $display("[TB] FAIL full_hold[%0d]: got int=%b en=%b out=%h expected int=1 en=0 out=%h",
                 i, bus.sctrl_interrupt, bus.sensor_en, bus.sctrl_out, m_mem[a]);
      end
    end
`ifdef SENSOR_BUF_DROP_CNT_EN
    vectors++;
    if (bus.sctrl_drop_cnt !== 8'd10) begin
      miscompares++; $display("[TB] FAIL full_drop_cnt: got %0d expected 10", bus.sctrl_drop_cnt);
    end
`endif
    tick(1, 1, 0, '0);
    vectors++;
    if (bus.sctrl_interrupt !== 1'b0 || bus.sensor_en !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL full_clear: got int=%b en=%b expected int=0 en=0", bus.sctrl_interrupt, bus.sensor_en);
    end
`ifdef SENSOR_BUF_DROP_CNT_EN
    vectors++;
    if (bus.sctrl_drop_cnt !== 8'd0) begin
      miscompares++; $display("[TB] FAIL clear_drop_cnt: got %0d expected 0", bus.sctrl_drop_cnt);
    end
`endif
    tick(1, 0, 0, '0);
    vectors++;
    if (bus.sensor_en !== 1'b1) begin
      miscompares++; $display("[TB] FAIL full_restart: got en=%b expected 1", bus.sensor_en);
    end
    old1 = m_mem[1];
    tick(1, 0, 1, 32'hCAFE_0000);
    bus.sctrl_addr = '0;
    #1;
    vectors++;
    if (bus.sctrl_out !== 32'hCAFE_0000) begin
      miscompares++; $display("[TB] FAIL full_new0: got %h expected cafe0000", bus.sctrl_out);
    end
    bus.sctrl_addr = ADDR_W'(1);
    #1;
    vectors++;
    if (bus.sctrl_out !== old1) begin
      miscompares++; $display("[TB] FAIL full_old1: got %h expected %h", bus.sctrl_out, old1);
    end
  endtask

  task automatic test_async_reset();
    tick(1, 1, 0, '0);
    tick(1, 0, 0, '0);
    for (int i = 0; i < 30; i++) tick(1, 0, 1, 32'h7700_0000 | 32'(i + 1));
    bus.sctrl_addr = ADDR_W'(3);
    #1;
    vectors++;
    if (bus.sctrl_out !== m_mem[3]) begin
      miscompares++; $display("[TB] FAIL arst_pre_out: got %h expected %h", bus.sctrl_out, m_mem[3]);
    end
    rst = 1'b0;
    #1;
    model_reset();
    vectors++;
    if (bus.sensor_en !== 1'b0 || bus.sctrl_interrupt !== 1'b0 || bus.sctrl_out !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL arst_outputs: got en=%b int=%b out=%h expected en=0 int=0 out=0",
               bus.sensor_en, bus.sctrl_interrupt, bus.sctrl_out);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    tick(1, 0, 0, '0);
    vectors++;
    if (bus.sensor_en !== 1'b1) begin
      miscompares++; $display("[TB] FAIL arst_restart: got en=%b expected 1", bus.sensor_en);
    end
    tick(1, 0, 1, 32'h5A5A_0001);
    bus.sctrl_addr = '0;
    #1;
    vectors++;
    if (bus.sctrl_out !== 32'h5A5A_0001) begin
      miscompares++; $display("[TB] FAIL arst_addr0: got %h expected 5a5a0001", bus.sctrl_out);
    end
    bus.sctrl_addr = ADDR_W'(1);
    #1;
    vectors++;
    if (bus.sctrl_out !== 32'h0) begin
      miscompares++; $display("[TB] FAIL arst_addr1: got %h expected 0", bus.sctrl_out);
    end
  endtask

  task automatic test_random();
    logic [ADDR_W-1:0] a;
    for (int i = 0; i < 600; i++) begin
      a = ADDR_W'($urandom_range(0, DEPTH - 1));
      bus.sctrl_addr = a;
      tick(($urandom % 8) != 0, ($urandom % 150) == 0, 1'($urandom % 2), $urandom);
      vectors++;
      if (bus.sensor_en !== exp_sensor_en() || bus.sctrl_interrupt !== m_full() ||
          bus.sctrl_out !== m_mem[a]) begin
        miscompares++;
        $display("[TB] FAIL random[%0d]: got en=%b int=%b out[%0d]=%h expected en=%b int=%b out=%h",
                 i, bus.sensor_en, bus.sctrl_interrupt, a, bus.sctrl_out,
                 exp_sensor_en(), m_full(), m_mem[a]);
      end
`ifdef SENSOR_BUF_DROP_CNT_EN
      vectors++;
      if (bus.sctrl_drop_cnt !== 8'(m_drops)) begin
        miscompares++;
        $display("[TB] FAIL random_drop_cnt[%0d]: got %0d expected %0d", i, bus.sctrl_drop_cnt, m_drops);
      end
`endif
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_basic_fill();
    test_gapped_paused();
    test_clear_priority();
    test_full_then_clear();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sensor_sample_buffer.md
# sensor_sample_buffer

Sample-buffer controller between the external sensor and the sensor AXI wrapper. While enabled, it captures one 32-bit sensor word per `sensor_ready` pulse into a 64-entry buffer and then raises an interrupt when the buffer is full. The wrapper reads any entry by word address and clears the buffer through `sctrl_clear`. It is the direct downstream consumer of the wrapper's `sctrl_en`, `sctrl_clear` and `sctrl_addr` register outputs.

## Interface
- `DEPTH`, 64: buffer entries; must be a power of two.
- `ADDR_W`, 6: log2(DEPTH).
- `DATA_W`, 32: sample width.

- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `sctrl_en`  in  1  collection enable (level).
- `sctrl_clear`  in  1  buffer clear (level; held while 1).
- `sctrl_addr`  in  ADDR_W  read word index.
- `sensor_ready`  in  1  sensor sample valid, one sample per high cycle.
- `sensor_out`  in  DATA_W  sensor sample.
- `sctrl_interrupt`  out  1  buffer full.
- `sctrl_out`  out  DATA_W  buffer entry at `sctrl_addr`.
- `sensor_en`  out  1  sensor request/enable.

## Operation
- The block has three states: IDLE, COLLECT and FULL. It also has a write pointer `wptr[ADDR_W-1:0]` and a DEPTH×DATA_W memory built from flops.
- **IDLE**
  - `sensor_en` = 0.
  - If `sctrl_clear` = 0 and `sctrl_en` = 1, go to COLLECT.
- **COLLECT**
  - `sensor_en` = 1.
  - On `sensor_ready` = 1, write `mem[wptr]` ← `sensor_out` and increment `wptr`.
  - If the write lands at `wptr` = DEPTH-1, `wptr` wraps to 0 and the state moves to FULL.
  - If `sctrl_en` = 0, return to IDLE with `wptr` and memory retained. A later re-enable resumes at the same `wptr`.
- **FULL**
  - `sensor_en` = 0 and `sctrl_interrupt` = 1.
  - `sensor_ready` is ignored.
  - Dropping `sctrl_en` does not leave FULL.
- **`sctrl_clear` = 1 (any state)**
  - Next state is IDLE, `wptr` ← 0 and `sctrl_interrupt` ← 0.
  - Memory contents are preserved, not zeroed.
  - Clear has priority over a write and over `sctrl_en` in the same cycle; that cycle's sample is dropped.
- **Reads**
  - `sctrl_out` = `mem[sctrl_addr]`, combinational, available in every state.
- **Ignored samples:** `sensor_ready` outside COLLECT is ignored.
- **Reset:** state IDLE, `wptr` 0, all memory entries 0, `sctrl_interrupt` 0, `sensor_en` 0, `sctrl_out` 0.

## Timing
- `sensor_en` and `sctrl_interrupt` are decoded from registered state and are glitch-free.
- `sensor_en` rises 1 cycle after the first cycle in which `sctrl_en` = 1 and `sctrl_clear` = 0 are seen in IDLE.
- **Write timing:** a sample presented in cycle N (COLLECT, `sensor_ready` = 1) is stored at the edge ending cycle N. It is visible on `sctrl_out` from cycle N+1.
- **Same-cycle read of the entry being written:** returns the old value.
- **Full transition:** the 64th write in cycle N gives FULL in cycle N+1. In that cycle `sctrl_interrupt` = 1 and `sensor_en` = 0. A `sensor_ready` in cycle N+1 is not stored.
- **Clear timing:**
  - `sctrl_clear` sampled 1 in cycle N gives `sctrl_interrupt` = 0 and `sensor_en` = 0 in cycle N+1.
  - Collection restarts 1 cycle after clear is released, provided `sctrl_en` = 1.
- **Reset mid-collection:** the asynchronous assertion forces all outputs to their reset values immediately. Partial samples are discarded.

## Configuration
- `SENSOR_BUF_DROP_CNT_EN` defined:
  - Adds output `sctrl_drop_cnt` (out, 8 bits). It is an 8-bit saturating count (max 255) of `sensor_ready` pulses received in FULL.
  - It resets to 0 on `rst` and on `sctrl_clear`.
- Undefined: the port and counter do not exist, and behaviour is otherwise identical.

## Test plan
- **Basic fill:**
  - Stimulus: reset, `sctrl_en` = 1, 64 samples with `sensor_ready` every cycle, values 0x100+i.
  - Response: `sctrl_interrupt` = 1 the cycle after the last write, and `sensor_en` = 0.
  - Readback of addresses 0..63 returns 0x100..0x13F.
- **Gapped and paused:**
  - Stimulus: `sensor_ready` on alternate cycles; drop `sctrl_en` after 10 samples for 5 cycles, then re-enable.
  - Response: `sensor_en` tracks enable with 1-cycle lag; exactly 64 samples are stored, in order, with no duplicates.
- **Clear priority:**
  - Stimulus: `sctrl_clear` = 1 in the same cycle as `sensor_ready` with 0xDEAD at `wptr` = 5.
  - Response: `mem[5]` is unchanged, `wptr` = 0, and the next sample lands at address 0.
- **Full then clear:**
  - Stimulus: fill the buffer, hold FULL for 20 cycles with `sensor_ready` toggling, then pulse clear for 1 cycle with `sctrl_en` = 1.
  - Response: contents are unchanged during FULL; interrupt drops 1 cycle after clear; collection restarts; old data is still readable until overwritten.
  - With the macro defined: `sctrl_drop_cnt` = 10 before clear and 0 after.
- **Async reset mid-fill:**
  - Stimulus: assert `rst` low after 30 samples.
  - Response: `sensor_en` = 0, `sctrl_interrupt` = 0 and `sctrl_out` = 0 immediately.
  - After release, a fresh fill starts at address 0.
